// File: rtl/gfx_fetch_pkg.sv
// ============================================================================
// Module : gfx_fetch_pkg
// Desc   : Shared fetch-channel state encoding, offset width and pixel decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gfx_fetch_pkg;

  localparam int OFFS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Four bit-planes interleaved into four 8-bit pixels, two columns per pixel.
  function automatic logic [31:0] gfx_decode(input logic [31:0] dout);
    logic [7:0]  a, b, c, d;
    logic [31:0] res;
    int          m;
    a   = dout[15:8];
    b   = dout[7:0];
    c   = dout[31:24];
    d   = dout[23:16];
    res = '0;
    for (int i = 0; i < 4; i++) begin
      m = 7 - 2 * i;
      res[8*i +: 8] = {d[m-1], b[m-1], c[m-1], a[m-1], d[m], b[m], c[m], a[m]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gfx_fetch_chan.sv
// ============================================================================
// Module : gfx_fetch_chan
// Desc   : One tile fetch channel (address build, ROM handshake, decode);
//          GFX_FETCH_CACHE_EN adds a one-entry decoded-data cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gfx_fetch_chan
  import gfx_fetch_pkg::*;
#(
  parameter  int BANK_W = 4,
  parameter  int TILE_W = 15,
  parameter  int NROM   = 2,
  localparam int SEL_W  = $clog2(NROM),
  localparam int ADDR_W = BANK_W + TILE_W + 5,
  localparam int ROM_AW = ADDR_W - SEL_W - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_cs,
  input  logic [TILE_W-1:0]        i_tile,
  input  logic [OFFS_W-1:0]        i_offs,
  input  logic [BANK_W-1:0]        i_bank,
  input  logic                     i_inval,
  input  logic [NROM-1:0]          i_rom_ok,
  input  logic [NROM*32-1:0]       i_rom_dout,
  output logic [31:0]              o_data,
  output logic                     o_data_ok,
  output logic [NROM-1:0]          o_rom_cs,
  output logic [NROM*ROM_AW-1:0]   o_rom_addr
);

  fetch_state_e                  state_q, state_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [ROM_AW-1:0]             word_q, word_d;
  logic [NROM-1:0]               rom_cs_q, rom_cs_d;
  logic [NROM-1:0][ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [31:0]                   data_q, data_d;
  logic                          data_ok_q, data_ok_d;

  logic [ADDR_W-1:0]             w_byte_addr;
  logic [SEL_W-1:0]              w_sel;
  logic [ROM_AW-1:0]             w_word;
  logic [NROM-1:0][31:0]         w_rom_dout;
  logic [31:0]                   w_fetched;
  logic                          w_hit;
  logic [31:0]                   w_cache_data;
  logic                          w_fill;
  logic                          unused_lsb;

  // Bank and tile concatenate exactly; only the offset add can wrap.
  assign w_byte_addr = {i_bank, i_tile, 5'b0} + ADDR_W'(i_offs);
  assign w_sel       = w_byte_addr[ADDR_W-1 -: SEL_W];
  assign w_word      = w_byte_addr[ADDR_W-SEL_W-1:1];
  assign unused_lsb  = w_byte_addr[0];
  assign w_rom_dout  = i_rom_dout;
  assign w_fetched   = gfx_decode(w_rom_dout[sel_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      word_q     <= '0;
      rom_cs_q   <= '0;
      rom_addr_q <= '0;
      data_q     <= '0;
      data_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      word_q     <= word_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      data_ok_q  <= data_ok_d;
    end
  end

  // A dropped request always wins over completion so no late DATA_OK escapes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_req_cs) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!i_req_cs)  state_d = ST_IDLE;
        else if (w_hit) state_d = ST_DONE;
        else            state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!i_req_cs)             state_d = ST_IDLE;
        else if (i_rom_ok[sel_q])  state_d = ST_DONE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d      = sel_q;
    word_d     = word_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    data_ok_d  = 1'b0;
    w_fill     = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (i_req_cs) begin
          sel_d  = w_sel;
          word_d = w_word;
          if (w_hit) begin
            data_d    = w_cache_data;
            data_ok_d = 1'b1;
          end else begin
            rom_cs_d          = '0;
            rom_cs_d[w_sel]   = 1'b1;
            rom_addr_d[w_sel] = w_word;
          end
        end else begin
          rom_cs_d = '0;
        end
      end
      ST_WAIT: begin
        if (!i_req_cs) begin
          rom_cs_d = '0;
        end else if (i_rom_ok[sel_q]) begin
          rom_cs_d  = '0;
          data_d    = w_fetched;
          data_ok_d = 1'b1;
          w_fill    = 1'b1;
        end
      end
      default: rom_cs_d = '0;
    endcase
  end

`ifdef GFX_FETCH_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [SEL_W-1:0]  cache_sel_q, cache_sel_d;
  logic [ROM_AW-1:0] cache_word_q, cache_word_d;
  logic [31:0]       cache_data_q, cache_data_d;

  assign w_hit        = cache_valid_q && (cache_sel_q == w_sel) && (cache_word_q == w_word);
  assign w_cache_data = cache_data_q;

  // Invalidation outranks a same-cycle refill.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_sel_d   = cache_sel_q;
    cache_word_d  = cache_word_q;
    cache_data_d  = cache_data_q;
    if (w_fill) begin
      cache_valid_d = 1'b1;
      cache_sel_d   = sel_q;
      cache_word_d  = word_q;
      cache_data_d  = w_fetched;
    end
    if (i_inval) cache_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_sel_q   <= '0;
      cache_word_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_sel_q   <= cache_sel_d;
      cache_word_q  <= cache_word_d;
      cache_data_q  <= cache_data_d;
    end
  end
`else
  logic unused_cache;
  assign w_hit        = 1'b0;
  assign w_cache_data = '0;
  assign unused_cache = i_inval ^ w_fill;
`endif

  assign o_data     = data_q;
  assign o_data_ok  = data_ok_q;
  assign o_rom_cs   = rom_cs_q;
  assign o_rom_addr = rom_addr_q;

endmodule

`default_nettype wire

// File: rtl/gfx_bank_fetch.sv
// ============================================================================
// Module : gfx_bank_fetch
// Desc   : Bank table plus NCH independent tile fetch channels; optional
//          per-channel cache enabled by GFX_FETCH_CACHE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gfx_bank_fetch
  import gfx_fetch_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int NSLOT  = 8,
  parameter  int BANK_W = 4,
  parameter  int TILE_W = 15,
  parameter  int NROM   = 2,
  localparam int SLOT_W = $clog2(NSLOT),
  localparam int SEL_W  = $clog2(NROM),
  localparam int ADDR_W = BANK_W + TILE_W + 5,
  localparam int ROM_AW = ADDR_W - SEL_W - 1
) (
  input  logic                         CLK96,
  input  logic                         RESET96_N,
  input  logic                         OBJECTBANK_WR,
  input  logic [SLOT_W-1:0]            OBJECTBANK_SLOT,
  input  logic [15:0]                  OBJECTBANK_DIN,
  input  logic [NCH-1:0]               REQ_CS,
  input  logic [NCH*TILE_W-1:0]        TILE_NUMBER,
  input  logic [NCH*OFFS_W-1:0]        TILE_OFFS,
  input  logic [NCH*SLOT_W-1:0]        TILE_BANK,
  output logic [NCH*32-1:0]            DATA,
  output logic [NCH-1:0]               DATA_OK,
  output logic [NCH*NROM-1:0]          ROM_CS,
  input  logic [NCH*NROM-1:0]          ROM_OK,
  output logic [NCH*NROM*ROM_AW-1:0]   ROM_ADDR,
  input  logic [NCH*NROM*32-1:0]       ROM_DOUT
);

  logic [NSLOT-1:0][BANK_W-1:0] bank_q, bank_d;
  logic                         unused_din;

  assign unused_din = ^OBJECTBANK_DIN;

  always_comb begin
    bank_d = bank_q;
    if (OBJECTBANK_WR) bank_d[OBJECTBANK_SLOT] = OBJECTBANK_DIN[BANK_W-1:0];
  end

  // Channels read bank_q, so a same-cycle write is seen only from the next cycle.
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) bank_q <= '0;
    else            bank_q <= bank_d;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    logic [SLOT_W-1:0] w_slot;
    assign w_slot = TILE_BANK[ch*SLOT_W +: SLOT_W];

    gfx_fetch_chan #(
      .BANK_W (BANK_W),
      .TILE_W (TILE_W),
      .NROM   (NROM)
    ) u_chan (
      .clk        (CLK96),
      .rst_n      (RESET96_N),
      .i_req_cs   (REQ_CS[ch]),
      .i_tile     (TILE_NUMBER[ch*TILE_W +: TILE_W]),
      .i_offs     (TILE_OFFS[ch*OFFS_W +: OFFS_W]),
      .i_bank     (bank_q[w_slot]),
      .i_inval    (OBJECTBANK_WR),
      .i_rom_ok   (ROM_OK[ch*NROM +: NROM]),
      .i_rom_dout (ROM_DOUT[ch*NROM*32 +: NROM*32]),
      .o_data     (DATA[ch*32 +: 32]),
      .o_data_ok  (DATA_OK[ch]),
      .o_rom_cs   (ROM_CS[ch*NROM +: NROM]),
      .o_rom_addr (ROM_ADDR[ch*NROM*ROM_AW +: NROM*ROM_AW])
    );
  end

endmodule

`default_nettype wire
